// File: rtl/alu_op_sequencer.sv
// Sequences one ALU select code per cycle for each set bit of op_mask, packing the outputs.
// Latency: result_valid rises popcount(op_mask) edges after start is accepted (same edge if mask is empty).
// Backpressure: result, result_valid and ALU drive hold in DONE until result_ready; start is ignored while busy.
module alu_op_sequencer #(
    parameter int OPW = 2,
    parameter int RW  = 2*OPW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OPW-1:0]  a_in,
    input  logic [OPW-1:0]  b_in,
    input  logic [3:0]      op_mask,
    output logic            busy,
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    output logic [1:0]      alu_sel,
    input  logic [RW-1:0]   alu_y,
    output logic [4*RW-1:0] result,
    output logic            result_valid,
    input  logic            result_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [3:0] mask_q;
    logic [1:0] first_sel;
    logic [1:0] next_sel;
    logic       has_next;

    // Descending scans so the lowest qualifying index wins.
    always_comb begin
        first_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (op_mask[i]) first_sel = 2'(i);
        end
    end

    always_comb begin
        has_next = 1'b0;
        next_sel = alu_sel;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (2'(i) > alu_sel)) begin
                has_next = 1'b1;
                next_sel = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mask_q       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= op_mask;
                        alu_a  <= a_in;
                        alu_b  <= b_in;
                        result <= '0;
                        if (op_mask != 4'd0) begin
                            alu_sel <= first_sel;
                            state   <= RUN;
                        end else begin
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                RUN: begin
                    result[RW*alu_sel +: RW] <= alu_y;
                    if (has_next) begin
                        alu_sel <= next_sel;
                    end else begin
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an XOR/select ALU stub; expected values are hand-computed.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  a_in = '0;
    logic [1:0]  b_in = '0;
    logic [3:0]  op_mask = '0;
    logic        busy;
    logic [1:0]  alu_a;
    logic [1:0]  alu_b;
    logic [1:0]  alu_sel;
    logic [3:0]  alu_y;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign alu_y = {alu_sel, alu_a ^ alu_b};

    alu_op_sequencer #(.OPW(2), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .op_mask(op_mask), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_y(alu_y), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic [3:0]  mask;
        logic [15:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency, check result, then handshake.
    task automatic run_req(input string name, input logic [1:0] a, input logic [1:0] b,
                           input logic [3:0] mask, input logic [15:0] exp_res, input int exp_lat);
        int lat;
        a_in = a; b_in = b; op_mask = mask; start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, " busy_at_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " result"}, 32'(result), 32'(exp_res));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({name, " valid_after_hs"}, 32'(result_valid), 32'd0);
        chk({name, " busy_after_hs"}, 32'(busy), 32'd0);
        chk({name, " result_held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        vecs[0] = '{a: 2'd2, b: 2'd1, mask: 4'hF, exp_res: 16'hFB73, exp_lat: 4};
        vecs[1] = '{a: 2'd3, b: 2'd0, mask: 4'hA, exp_res: 16'hF070, exp_lat: 2};
        vecs[2] = '{a: 2'd1, b: 2'd3, mask: 4'h1, exp_res: 16'h0002, exp_lat: 1};
        vecs[3] = '{a: 2'd0, b: 2'd1, mask: 4'h8, exp_res: 16'hD000, exp_lat: 1};
        vecs[4] = '{a: 2'd2, b: 2'd2, mask: 4'h6, exp_res: 16'h0840, exp_lat: 2};
        vecs[5] = '{a: 2'd3, b: 2'd3, mask: 4'h0, exp_res: 16'h0000, exp_lat: 0};

        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_b", 32'(alu_b), 32'd0);
        chk("reset alu_sel", 32'(alu_sel), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset valid", 32'(result_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Empty mask straight from reset: alu_sel must not move from 0.
        a_in = 2'd1; b_in = 2'd2; op_mask = 4'h0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty valid_at_accept", 32'(result_valid), 32'd1);
        chk("empty result", 32'(result), 32'd0);
        chk("empty alu_sel", 32'(alu_sel), 32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("empty hs idle", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++)
            run_req($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mask,
                    vecs[i].exp_res, vecs[i].exp_lat);

        // Full mask with select stepping and input scrambling during RUN.
        a_in = 2'd2; b_in = 2'd1; op_mask = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("step sel%0d", s), 32'(alu_sel), 32'(s));
            chk($sformatf("step valid%0d", s), 32'(result_valid), 32'd0);
            a_in = 2'($urandom); b_in = 2'($urandom); op_mask = 4'($urandom);
            tick();
        end
        chk("isolate valid", 32'(result_valid), 32'd1);
        chk("isolate result", 32'(result), 32'hFB73);
        chk("isolate alu_a", 32'(alu_a), 32'd2);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("isolate idle", 32'(busy), 32'd0);

        // Backpressure: hold in DONE for 5 cycles, start pulsed and ignored.
        a_in = 2'd1; b_in = 2'd1; op_mask = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("bp valid", 32'(result_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2); a_in = 2'd3; b_in = 2'd0; op_mask = 4'h1;
            tick();
            chk($sformatf("bp hold valid%0d", c), 32'(result_valid), 32'd1);
            chk($sformatf("bp hold result%0d", c), 32'(result), 32'hC840);
        end
        start = 1'b1; result_ready = 1'b1;
        tick();
        start = 1'b0; result_ready = 1'b0;
        chk("bp hs valid", 32'(result_valid), 32'd0);
        chk("bp hs start_ignored", 32'(busy), 32'd0);
        tick();
        chk("bp no queue", 32'(busy), 32'd0);
        chk("bp result held idle", 32'(result), 32'hC840);

        // Reset while alu_sel==2 in RUN.
        a_in = 2'd2; b_in = 2'd1; op_mask = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid sel before reset", 32'(alu_sel), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset sel", 32'(alu_sel), 32'd0);
        chk("mid reset alu_a", 32'(alu_a), 32'd0);
        chk("mid reset result", 32'(result), 32'd0);
        chk("mid reset valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_req("post_reset", 2'd3, 2'd1, 4'h5, 16'h0A02, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, limit 50000 required less");
        $fatal(1);
    end

endmodule
